// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared width constant and opcode encoding for the adder issue stage.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int unsigned c_ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_flag_calc.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_calc
// Brief    : Combinational zero/negative/signed-overflow flags from a sum and
//            the MSBs of the two adder operands.
// Revision : 1.0
// ============================================================================
module alu_flag_calc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_result,
    input  logic             i_a_msb,
    input  logic             i_b_msb,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf
);

    assign o_zero = (i_result == '0);
    assign o_neg  = i_result[WIDTH-1];
    // Operands already carry the SUB inversion, so one rule covers all ops.
    assign o_ovf  = (i_a_msb == i_b_msb) && (i_result[WIDTH-1] != i_a_msb);

endmodule
`default_nettype wire

// File: rtl/adder_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : adder_issue_stage
// Brief    : Two-stage issue/retire wrapper around an external adder with an
//            architectural carry flag. ALU_FLAGS_EN enables ovf/zero/neg.
// Revision : 1.0
// ============================================================================
module adder_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = c_ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] adder_in0,
    output logic [WIDTH-1:0] adder_in1,
    output logic             carry_in,
    input  logic [WIDTH-1:0] adder_out,
    input  logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic             r_cflag;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    alu_op_t          r_op;

    logic             w_s2_adv;
    logic             w_in_accept;
    logic             w_op_sub;

    assign w_s2_adv    = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready    = !r_s1_valid || w_s2_adv;
    assign w_in_accept = in_valid && in_ready;

    assign w_op_sub  = (r_op == OP_SUB) || (r_op == OP_SBC);
    assign adder_in0 = r_a;
    assign adder_in1 = w_op_sub ? ~r_b : r_b;

    // SBC uses C=1 as "no borrow", so both chained ops pass cflag straight in.
    always_comb begin
        carry_in = 1'b0;
        case (r_op)
            OP_ADD:  carry_in = 1'b0;
            OP_ADC:  carry_in = r_cflag;
            OP_SUB:  carry_in = 1'b1;
            OP_SBC:  carry_in = r_cflag;
            default: carry_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_accept) begin
                r_a  <= in_a;
                r_b  <= in_b;
                r_op <= alu_op_t'(in_op);
            end
        end
    end

    // cflag moves with the op leaving stage 1, so a following ADC/SBC sees it next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_cflag    <= 1'b0;
        end else begin
            if (!r_s2_valid || out_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv) begin
                r_result <= adder_out;
                r_carry  <= carry_out;
                r_cflag  <= carry_out;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_carry  = r_carry;

`ifdef ALU_FLAGS_EN
    logic w_zero;
    logic w_neg;
    logic w_ovf;
    logic r_zero;
    logic r_neg;
    logic r_ovf;

    alu_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .i_result (adder_out),
        .i_a_msb  (adder_in0[WIDTH-1]),
        .i_b_msb  (adder_in1[WIDTH-1]),
        .o_zero   (w_zero),
        .o_neg    (w_neg),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_zero <= w_zero;
            r_neg  <= w_neg;
            r_ovf  <= w_ovf;
        end
    end

    assign out_zero = r_zero;
    assign out_neg  = r_neg;
    assign out_ovf  = r_ovf;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
    assign out_ovf  = 1'b0;
`endif

endmodule
`default_nettype wire
